control_unit: RTL
=================

Name: control_unit

Overview:
- Hardwired multi-cycle control unit for the 32-bit bus-based CPU.
- Sequences fetch and execute by driving the register select/encode strobes (Gra/Grb/Grc, Rin/Rout/BAout, Cout), bus drivers, the memory handshake and the ALU op.
- Takes OP (IR[31:27]) from the select/encode logic and the CON FF result.
- Sits beside the datapath; it is the only source of datapath control strobes.

Parameters:
- STEP_W, 3, width of the T-step counter (max step T7).

Ports:
- clock  input  1  system clock, rising edge.
- reset_n  input  1  synchronous, active-low reset.
- op  input  5  opcode from IR[31:27].
- con_ff  input  1  branch condition flip-flop output.
- mem_ready  input  1  memory completes the current Read/Write this cycle.
- step_req  input  1  single-step advance pulse (used only with CU_SINGLE_STEP_EN).
- ctrl  output  24  packed strobe vector, field order fixed in cu_pkg.
- alu_op  output  5  ALU operation select.
- run  output  1  high while executing, low when halted.
- illegal_op  output  1  sticky; set on an undefined opcode.

Behaviour:
- State register: {phase ∈ FETCH, EXEC, HALTED, WAIT_STEP; step 0..7}.
- Outputs are Moore-decoded from state plus the opcode latched at the end of T2 (op_q).
- Reset:
  - reset_n low at a clock edge forces FETCH/T0 and clears op_q and illegal_op.
  - While reset_n is low, ctrl = 0, alu_op = 0 and run = 0 (outputs gated).
  - Reset mid-operation abandons any Read/Write; Read/Write drop the same cycle reset_n is sampled low.
- Fetch:
  - T0: PCout, MARin, IncPC, Zin.
  - T1: Zlowout, PCin, Read, MDRin. Held while mem_ready = 0; re-asserting PCin loads the same Z value.
  - T2: MDRout, IRin. op_q <= op.
- Execute, from T3 (alu_op defaults to ADD):
  - ADD/SUB/AND/OR:
    - T3: Grb, Rout, Yin.
    - T4: Grc, Rout, Zin, alu_op = op-mapped.
    - T5: Zlowout, Gra, Rin.
  - ADDI: T3 Grb, Rout, Yin. T4 Cout, Zin. T5 Zlowout, Gra, Rin.
  - LD:
    - T3: Grb, BAout, Yin.
    - T4: Cout, Zin.
    - T5: Zlowout, MARin.
    - T6: Read, MDRin; wait on mem_ready.
    - T7: MDRout, Gra, Rin.
  - ST:
    - T3–T5: as LD.
    - T6: Gra, Rout, MDRin.
    - T7: Write; wait on mem_ready.
  - BR:
    - T3: Gra, Rout, CONin.
    - T4: PCout, Yin.
    - T5: Cout, Zin.
    - T6: Zlowout, plus PCin only if con_ff = 1.
  - JR: T3 Gra, Rout, PCin.
  - NOP: no strobes in T3.
  - HALT: T3 enters HALTED.
  - Undefined opcode: illegal_op <= 1, executed as NOP.
- Completion:
  - After the final step of an instruction, next state is FETCH/T0.
  - Cycle counts with zero wait: R-type 6, LD 8, ST 8, BR 7, JR 4, NOP 4.
- Wait states: a memory wait step is exited on the cycle mem_ready = 1. mem_ready outside a Read/Write step is ignored.
- HALTED: ctrl = 0, run = 0; only reset_n leaves it.
- At most one bus driver (PCout, Zlowout, MDRout, Rout, BAout, Cout) is asserted per cycle; this is an assertable invariant.

Optional Feature:
- Macro: CU_SINGLE_STEP_EN.
- Defined:
  - After each instruction's final step, enter WAIT_STEP with ctrl = 0 and run = 1.
  - A cycle with step_req = 1 moves to FETCH/T0.
  - step_req in any other state is ignored.
- Undefined: WAIT_STEP does not exist, step_req is unused, and execution is back-to-back.

Decomposition:
- cu_pkg holds:
  - opcode constants: LD=00000, ST=00010, ADD=00011, SUB=00100, AND=00101, OR=00110, ADDI=01000, BR=10010, JR=10100, NOP=11010, HALT=11011;
  - alu_op encodings;
  - phase enum;
  - ctrl field indices, LSB first: PCout, MARin, IncPC, Zin, Zlowout, PCin, Read, Write, MDRin, MDRout, IRin, Yin, Gra, Grb, Grc, Rin, Rout, BAout, Cout, CONin, Zhighout, HIin, LOin, Run.
- One sub-module, cu_step_decode: combinational {phase, step, op_q, con_ff} -> {ctrl, alu_op}. The top module holds the state, wait and step logic.

Test Plan:
- Reset held 2 cycles, then released: ctrl = 0 during reset; first cycle after release has PCout, MARin, IncPC, Zin = 1 and run = 1.
- ADD with mem_ready tied 1: T0–T5 strobes exactly as listed; alu_op = ADD at T4; next T0 at cycle 7.
- LD with mem_ready low 3 cycles in T1 and 2 cycles in T6: Read held 4 cycles and 3 cycles respectively; total 13 cycles.
- BR with con_ff = 0, then con_ff = 1: PCin at T6 absent, then present; both return to T0.
- HALT, then mem_ready/op toggling for 10 cycles: run = 0 and ctrl = 0 throughout; reset_n low restarts at T0.
- Opcode 11111 sets illegal_op, which stays set through a following ADD; with CU_SINGLE_STEP_EN, after the ADD the unit idles in WAIT_STEP until a step_req pulse.

Source files
------------

// File: rtl/cu_pkg.sv
// Shared encodings for the hardwired control unit: opcodes, ALU ops, phases, strobe indices.
// Pure declarations and helpers; no latency.
// No flow control; all users are combinational decoders or the state register.
package cu_pkg;

    localparam int CU_STEP_W = 3;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ADDI = 5'b01000;
    localparam logic [4:0] OP_BR   = 5'b10010;
    localparam logic [4:0] OP_JR   = 5'b10100;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    // ALU selects reuse the matching R-type opcode value.
    localparam logic [4:0] ALU_ADD = 5'b00011;
    localparam logic [4:0] ALU_SUB = 5'b00100;
    localparam logic [4:0] ALU_AND = 5'b00101;
    localparam logic [4:0] ALU_OR  = 5'b00110;

    typedef enum logic [1:0] {
        PH_FETCH     = 2'd0,
        PH_EXEC      = 2'd1,
        PH_HALTED    = 2'd2,
        PH_WAIT_STEP = 2'd3
    } phase_t;

    localparam int CTRL_W        = 24;
    localparam int CTRL_PCOUT    = 0;
    localparam int CTRL_MARIN    = 1;
    localparam int CTRL_INCPC    = 2;
    localparam int CTRL_ZIN      = 3;
    localparam int CTRL_ZLOWOUT  = 4;
    localparam int CTRL_PCIN     = 5;
    localparam int CTRL_READ     = 6;
    localparam int CTRL_WRITE    = 7;
    localparam int CTRL_MDRIN    = 8;
    localparam int CTRL_MDROUT   = 9;
    localparam int CTRL_IRIN     = 10;
    localparam int CTRL_YIN      = 11;
    localparam int CTRL_GRA      = 12;
    localparam int CTRL_GRB      = 13;
    localparam int CTRL_GRC      = 14;
    localparam int CTRL_RIN      = 15;
    localparam int CTRL_ROUT     = 16;
    localparam int CTRL_BAOUT    = 17;
    localparam int CTRL_COUT     = 18;
    localparam int CTRL_CONIN    = 19;
    localparam int CTRL_ZHIGHOUT = 20;
    localparam int CTRL_HIIN     = 21;
    localparam int CTRL_LOIN     = 22;
    localparam int CTRL_RUN      = 23;

    typedef logic [CTRL_W-1:0] ctrl_t;

    function automatic logic op_is_legal(input logic [4:0] op);
        case (op)
            OP_LD, OP_ST, OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_ADDI, OP_BR, OP_JR, OP_NOP, OP_HALT: op_is_legal = 1'b1;
            default:                                op_is_legal = 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] op_last_step(input logic [4:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI: op_last_step = 3'd5;
            OP_LD, OP_ST:                           op_last_step = 3'd7;
            OP_BR:                                  op_last_step = 3'd6;
            default:                                op_last_step = 3'd3;
        endcase
    endfunction

    // Step that stalls on mem_ready; 0 means the instruction never waits in execute.
    function automatic logic [2:0] op_wait_step(input logic [4:0] op);
        case (op)
            OP_LD:   op_wait_step = 3'd6;
            OP_ST:   op_wait_step = 3'd7;
            default: op_wait_step = 3'd0;
        endcase
    endfunction

    function automatic logic [4:0] alu_of_op(input logic [4:0] op);
        case (op)
            OP_SUB:  alu_of_op = ALU_SUB;
            OP_AND:  alu_of_op = ALU_AND;
            OP_OR:   alu_of_op = ALU_OR;
            default: alu_of_op = ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/cu_step_decode.sv
// Moore strobe decoder: {phase, step, op_q, con_ff} -> {ctrl, alu_op}.
// Purely combinational, zero latency.
// No flow control; wait-state holding is done by the state register in the top.
module cu_step_decode
    import cu_pkg::*;
#(
    parameter int STEP_W = CU_STEP_W
) (
    input  phase_t            phase,
    input  logic [STEP_W-1:0] step,
    input  logic [4:0]        op_q,
    input  logic              con_ff,
    output ctrl_t             ctrl,
    output logic [4:0]        alu_op
);

    always_comb begin
        ctrl   = '0;
        alu_op = ALU_ADD;
        case (phase)
            PH_FETCH: begin
                ctrl[CTRL_RUN] = 1'b1;
                case (int'(step))
                    0: begin
                        ctrl[CTRL_PCOUT] = 1'b1; ctrl[CTRL_MARIN] = 1'b1;
                        ctrl[CTRL_INCPC] = 1'b1; ctrl[CTRL_ZIN]   = 1'b1;
                    end
                    1: begin
                        ctrl[CTRL_ZLOWOUT] = 1'b1; ctrl[CTRL_PCIN]  = 1'b1;
                        ctrl[CTRL_READ]    = 1'b1; ctrl[CTRL_MDRIN] = 1'b1;
                    end
                    2: begin
                        ctrl[CTRL_MDROUT] = 1'b1; ctrl[CTRL_IRIN] = 1'b1;
                    end
                    default: ;
                endcase
            end
            PH_EXEC: begin
                ctrl[CTRL_RUN] = 1'b1;
                case (op_q)
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI: begin
                        case (int'(step))
                            3: begin
                                ctrl[CTRL_GRB] = 1'b1; ctrl[CTRL_ROUT] = 1'b1; ctrl[CTRL_YIN] = 1'b1;
                            end
                            4: begin
                                ctrl[CTRL_ZIN] = 1'b1;
                                if (op_q == OP_ADDI) begin
                                    ctrl[CTRL_COUT] = 1'b1;
                                end else begin
                                    ctrl[CTRL_GRC] = 1'b1; ctrl[CTRL_ROUT] = 1'b1;
                                    alu_op = alu_of_op(op_q);
                                end
                            end
                            5: begin
                                ctrl[CTRL_ZLOWOUT] = 1'b1; ctrl[CTRL_GRA] = 1'b1; ctrl[CTRL_RIN] = 1'b1;
                            end
                            default: ;
                        endcase
                    end
                    OP_LD, OP_ST: begin
                        case (int'(step))
                            3: begin
                                ctrl[CTRL_GRB] = 1'b1; ctrl[CTRL_BAOUT] = 1'b1; ctrl[CTRL_YIN] = 1'b1;
                            end
                            4: begin
                                ctrl[CTRL_COUT] = 1'b1; ctrl[CTRL_ZIN] = 1'b1;
                            end
                            5: begin
                                ctrl[CTRL_ZLOWOUT] = 1'b1; ctrl[CTRL_MARIN] = 1'b1;
                            end
                            6: begin
                                ctrl[CTRL_MDRIN] = 1'b1;
                                if (op_q == OP_LD) begin
                                    ctrl[CTRL_READ] = 1'b1;
                                end else begin
                                    ctrl[CTRL_GRA] = 1'b1; ctrl[CTRL_ROUT] = 1'b1;
                                end
                            end
                            7: begin
                                if (op_q == OP_LD) begin
                                    ctrl[CTRL_MDROUT] = 1'b1; ctrl[CTRL_GRA] = 1'b1; ctrl[CTRL_RIN] = 1'b1;
                                end else begin
                                    ctrl[CTRL_WRITE] = 1'b1;
                                end
                            end
                            default: ;
                        endcase
                    end
                    OP_BR: begin
                        case (int'(step))
                            3: begin
                                ctrl[CTRL_GRA] = 1'b1; ctrl[CTRL_ROUT] = 1'b1; ctrl[CTRL_CONIN] = 1'b1;
                            end
                            4: begin
                                ctrl[CTRL_PCOUT] = 1'b1; ctrl[CTRL_YIN] = 1'b1;
                            end
                            5: begin
                                ctrl[CTRL_COUT] = 1'b1; ctrl[CTRL_ZIN] = 1'b1;
                            end
                            6: begin
                                ctrl[CTRL_ZLOWOUT] = 1'b1; ctrl[CTRL_PCIN] = con_ff;
                            end
                            default: ;
                        endcase
                    end
                    OP_JR: begin
                        if (int'(step) == 3) begin
                            ctrl[CTRL_GRA] = 1'b1; ctrl[CTRL_ROUT] = 1'b1; ctrl[CTRL_PCIN] = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Hardwired multi-cycle CPU control unit; CU_SINGLE_STEP_EN adds a WAIT_STEP idle between instructions.
// Latency: Moore outputs, one T-step per clock; reset_n gates outputs combinationally.
// Backpressure: mem_ready=0 holds fetch T1, LD T6 and ST T7; step_req releases WAIT_STEP.
module control_unit
    import cu_pkg::*;
#(
    parameter int STEP_W = CU_STEP_W
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [4:0]  op,
    input  logic        con_ff,
    input  logic        mem_ready,
    input  logic        step_req,
    output logic [23:0] ctrl,
    output logic [4:0]  alu_op,
    output logic        run,
    output logic        illegal_op
);

`ifdef CU_SINGLE_STEP_EN
    localparam phase_t DONE_PHASE = PH_WAIT_STEP;
`else
    localparam phase_t DONE_PHASE = PH_FETCH;
    logic unused_step_req;
    assign unused_step_req = step_req;
`endif

    phase_t            phase, phase_nxt;
    logic [STEP_W-1:0] step, step_nxt;
    logic [4:0]        op_q;
    logic              in_mem_wait;
    logic              at_last_step;
    ctrl_t             dec_ctrl;
    logic [4:0]        dec_alu;

    assign in_mem_wait  = (op_wait_step(op_q) != 3'd0) && (step == STEP_W'(op_wait_step(op_q))) && !mem_ready;
    assign at_last_step = (step == STEP_W'(op_last_step(op_q)));

    always_comb begin
        phase_nxt = phase;
        step_nxt  = step;
        case (phase)
            PH_FETCH: begin
                if (int'(step) >= 2) begin
                    phase_nxt = PH_EXEC;
                    step_nxt  = STEP_W'(3);
                end else if (int'(step) != 1 || mem_ready) begin
                    step_nxt = step + STEP_W'(1);
                end
            end
            PH_EXEC: begin
                if (op_q == OP_HALT) begin
                    phase_nxt = PH_HALTED;
                    step_nxt  = '0;
                end else if (!in_mem_wait) begin
                    if (at_last_step) begin
                        phase_nxt = DONE_PHASE;
                        step_nxt  = '0;
                    end else begin
                        step_nxt = step + STEP_W'(1);
                    end
                end
            end
            PH_WAIT_STEP: begin
`ifdef CU_SINGLE_STEP_EN
                if (step_req) begin
                    phase_nxt = PH_FETCH;
                    step_nxt  = '0;
                end
`else
                phase_nxt = PH_FETCH;
                step_nxt  = '0;
`endif
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            phase      <= PH_FETCH;
            step       <= '0;
            op_q       <= '0;
            illegal_op <= 1'b0;
        end else begin
            phase <= phase_nxt;
            step  <= step_nxt;
            // Opcode is captured as IR loads, so decode sees it from T3 on.
            if (phase == PH_FETCH && int'(step) == 2) begin
                op_q <= op;
                if (!op_is_legal(op)) begin
                    illegal_op <= 1'b1;
                end
            end
        end
    end

    cu_step_decode #(.STEP_W(STEP_W)) u_decode (
        .phase  (phase),
        .step   (step),
        .op_q   (op_q),
        .con_ff (con_ff),
        .ctrl   (dec_ctrl),
        .alu_op (dec_alu)
    );

    // Gating on reset_n drops an in-flight Read/Write in the very cycle reset is seen.
    assign ctrl   = reset_n ? dec_ctrl : '0;
    assign alu_op = reset_n ? dec_alu : '0;
    assign run    = reset_n && (phase != PH_HALTED);

    logic [5:0] bus_drv;
    assign bus_drv = {ctrl[CTRL_PCOUT], ctrl[CTRL_ZLOWOUT], ctrl[CTRL_MDROUT],
                      ctrl[CTRL_ROUT], ctrl[CTRL_BAOUT], ctrl[CTRL_COUT]};

    a_one_bus_driver: assert property (@(posedge clock) disable iff (!reset_n) $onehot0(bus_drv));

endmodule
